// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: pipeline request/response and memory-bus signals of lsu_ctrl
interface lsu_ctrl_if #(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 32
);
   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [2:0]         req_funct3;
   logic [A_WIDTH-1:0] req_addr;
   logic [D_WIDTH-1:0] req_wdata;
   logic               rsp_valid;
   logic [D_WIDTH-1:0] rsp_rdata;
   logic               rsp_err;
   logic               mem_req;
   logic               mem_gnt;
   logic [A_WIDTH-1:0] mem_addr;
   logic               mem_we;
   logic [3:0]         mem_be;
   logic [D_WIDTH-1:0] mem_wdata;
   logic               mem_rvalid;
   logic [D_WIDTH-1:0] mem_rdata;
   // master: the pipeline and memory around the controller; slave: lsu_ctrl itself
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_addr, mem_we, mem_be, mem_wdata
   );
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_addr, mem_we, mem_be, mem_wdata
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store controller; define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses into two word accesses
module lsu_ctrl #(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 32
) (
   input logic       clk,
   input logic       rst_n,
   lsu_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
   state_t               state_q;
   logic                 we_q;
   logic                 split_q;
   logic [2:0]           f3_q;
   logic [1:0]           off_q;
   logic [A_WIDTH-1:0]   waddr_q;
   logic [3:0]           be_hi_q;
   logic [D_WIDTH-1:0]   wd_hi_q;
   logic [D_WIDTH-1:0]   word0_q;
   logic                 mem_req_q;
   logic                 mem_we_q;
   logic [A_WIDTH-1:0]   mem_addr_q;
   logic [3:0]           mem_be_q;
   logic [D_WIDTH-1:0]   mem_wdata_q;
   logic                 rsp_valid_q;
   logic                 rsp_err_q;
   logic [D_WIDTH-1:0]   rsp_rdata_q;
   logic [2:0]           req_sz;
   logic                 req_bad;
   logic                 req_split;
   logic                 req_err;
   logic [7:0]           req_be;
   logic [2*D_WIDTH-1:0] req_wd;
`ifndef LSU_MISALIGNED_SPLIT_EN
   logic                 req_mis;
`endif

   // Pick the addressed byte/half/word out of the two-word window {word1,word0} and extend it
   function automatic logic [D_WIDTH-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off, input logic [2*D_WIDTH-1:0] win);
      logic [D_WIDTH-1:0] s;
      s = D_WIDTH'(win >> {off, 3'b000});
      return f3[1] ? s
           : f3[0] ? {{(D_WIDTH-16){s[15] & ~f3[2]}}, s[15:0]}
           : {{(D_WIDTH-8){s[7] & ~f3[2]}}, s[7:0]};
   endfunction

   // Decode the incoming request: size, legality, split need and 64-bit lane-aligned enables/data
   always_comb begin
      req_sz    = bus.req_funct3[1] ? 3'd4 : bus.req_funct3[0] ? 3'd2 : 3'd1;
      req_bad   = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3[2] && (bus.req_funct3[1] || bus.req_we));
      req_split = ({1'b0, bus.req_addr[1:0]} + req_sz) > 3'd4;
      req_be    = {4'b0000, bus.req_funct3[1] ? 4'b1111 : bus.req_funct3[0] ? 4'b0011 : 4'b0001} << bus.req_addr[1:0];
      req_wd    = {{D_WIDTH{1'b0}}, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
      req_err   = req_bad;
`else
      req_mis   = (bus.req_funct3[0] && bus.req_addr[0]) || (bus.req_funct3[1] && bus.req_addr[1:0] != 2'b00);
      req_err   = req_bad || req_mis;
`endif
   end

   // Access sequencer; every bus and response output is a register updated here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         split_q     <= 1'b0;
         f3_q        <= '0;
         off_q       <= '0;
         waddr_q     <= '0;
         be_hi_q     <= '0;
         wd_hi_q     <= '0;
         word0_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         case (state_q)
            IDLE: if (bus.req_valid) begin
               we_q    <= bus.req_we;
               split_q <= req_split;
               f3_q    <= bus.req_funct3;
               off_q   <= bus.req_addr[1:0];
               waddr_q <= {bus.req_addr[A_WIDTH-1:2], 2'b00};
               be_hi_q <= bus.req_we ? req_be[7:4] : 4'b0000;
               wd_hi_q <= bus.req_we ? req_wd[2*D_WIDTH-1:D_WIDTH] : '0;
               if (req_err) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
               end else begin
                  state_q     <= REQ0;
                  mem_req_q   <= 1'b1;
                  mem_addr_q  <= {bus.req_addr[A_WIDTH-1:2], 2'b00};
                  mem_we_q    <= bus.req_we;
                  mem_be_q    <= bus.req_we ? req_be[3:0] : 4'b0000;
                  mem_wdata_q <= bus.req_we ? req_wd[D_WIDTH-1:0] : '0;
               end
            end
            REQ0, REQ1: if (bus.mem_gnt) begin
               state_q   <= (state_q == REQ0) ? WAIT0 : WAIT1;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
               mem_be_q  <= '0;
            end
            WAIT0: if (bus.mem_rvalid) begin
               word0_q <= bus.mem_rdata;
               if (split_q) begin
                  state_q     <= REQ1;
                  mem_req_q   <= 1'b1;
                  mem_addr_q  <= waddr_q + A_WIDTH'(4);
                  mem_we_q    <= we_q;
                  mem_be_q    <= be_hi_q;
                  mem_wdata_q <= wd_hi_q;
               end else begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= we_q ? '0 : load_ext(f3_q, off_q, {{D_WIDTH{1'b0}}, bus.mem_rdata});
               end
            end
            WAIT1: if (bus.mem_rvalid) begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= we_q ? '0 : load_ext(f3_q, off_q, {bus.mem_rdata, word0_q});
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule
